// File: rtl/cache_lu_arbiter.sv
// rtl/cache_lu_arbiter.sv - Lookup-pipe round-robin arbiter; optional fill priority via CACHE_LU_ARB_FILL_PRIO_EN
module cache_lu_arbiter #(
    parameter int NUM_REQ    = 8,
    parameter int ID_W       = 3,
    parameter int ADRS_W     = 20,
    parameter int CL_W       = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*2-1:0]     req_op,
    input  logic [NUM_REQ*ADRS_W-1:0] req_address,
    input  logic [NUM_REQ*CL_W-1:0]  req_cl_data,
    output logic [NUM_REQ-1:0]       req_grant,
    input  logic                     pipe_ready,
    output logic                     lu_req_valid,
    output logic [1:0]               lu_req_op,
    output logic [ID_W-1:0]          lu_req_tq_id,
    output logic [ADRS_W-1:0]        lu_req_address,
    output logic [CL_W-1:0]          lu_req_cl_data
);
    localparam logic [1:0] OP_NO_LU   = 2'd0;
    localparam logic [1:0] OP_FILL_LU = 2'd3;

    logic                r_lu_valid;
    logic [1:0]          r_lu_op;
    logic [ID_W-1:0]     r_lu_tq_id;
    logic [ADRS_W-1:0]   r_lu_address;
    logic [CL_W-1:0]     r_lu_cl_data;
    logic [ID_W-1:0]     r_rr_ptr;

    logic [NUM_REQ-1:0]  w_eligible;
    logic [NUM_REQ-1:0]  w_fill_mask;
    logic [NUM_REQ-1:0]  w_rw_mask;
    logic [NUM_REQ-1:0]  w_search_mask;
    logic                w_slot_free;
    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W-1:0]     w_idx;
    logic                w_grant_en;

    always_comb begin
        w_eligible  = '0;
        w_fill_mask = '0;
        w_rw_mask   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i]  = req_valid[i] && (req_op[i*2 +: 2] != OP_NO_LU);
            w_fill_mask[i] = w_eligible[i] && (req_op[i*2 +: 2] == OP_FILL_LU);
            w_rw_mask[i]   = w_eligible[i] && (req_op[i*2 +: 2] != OP_FILL_LU);
        end
    end

`ifdef CACHE_LU_ARB_FILL_PRIO_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0] r_starve_cnt;
    logic            w_force_rw;

    // Fills win unless RD/WR traffic has been starved for STARVE_MAX fill grants.
    always_comb begin
        w_force_rw    = (r_starve_cnt == SC_W'(STARVE_MAX)) && (|w_rw_mask);
        w_search_mask = ((|w_fill_mask) && !w_force_rw) ? w_fill_mask : w_rw_mask;
    end
`else
    always_comb begin
        w_search_mask = w_eligible;
    end
`endif

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = r_rr_ptr + ID_W'(k);
            if (!w_found && w_search_mask[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_slot_free = !r_lu_valid || pipe_ready;
        w_grant_en  = w_found && w_slot_free && !rst;
        req_grant   = '0;
        if (w_grant_en) begin
            req_grant[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lu_valid   <= 1'b0;
            r_lu_op      <= '0;
            r_lu_tq_id   <= '0;
            r_lu_address <= '0;
            r_lu_cl_data <= '0;
            r_rr_ptr     <= '0;
        end else if (w_grant_en) begin
            r_lu_valid   <= 1'b1;
            r_lu_op      <= req_op[w_winner*2 +: 2];
            r_lu_tq_id   <= w_winner;
            r_lu_address <= req_address[w_winner*ADRS_W +: ADRS_W];
            r_lu_cl_data <= req_cl_data[w_winner*CL_W +: CL_W];
            r_rr_ptr     <= w_winner + ID_W'(1);
        end else if (pipe_ready) begin
            r_lu_valid   <= 1'b0;
        end
    end

`ifdef CACHE_LU_ARB_FILL_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst || !(|w_rw_mask)) begin
            r_starve_cnt <= '0;
        end else if (w_grant_en) begin
            if (req_op[w_winner*2 +: 2] != OP_FILL_LU) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != SC_W'(STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + SC_W'(1);
            end
        end
    end
`endif

    assign lu_req_valid   = r_lu_valid;
    assign lu_req_op      = r_lu_op;
    assign lu_req_tq_id   = r_lu_tq_id;
    assign lu_req_address = r_lu_address;
    assign lu_req_cl_data = r_lu_cl_data;

endmodule

// File: doc/cache_lu_arbiter.md
# cache_lu_arbiter

Lookup-pipe arbiter for the cache. It picks one request per cycle from the transaction-queue (TQ) entries that want to enter the lookup pipeline: core reads (RD_LU), core writes (WR_LU) and far-memory fills (FILL_LU). The winner goes into a registered lookup-request slot that drives the pipe input. Sits between the TQ entry array and the first lookup-pipe stage; the pipe's ready signal back-pressures it.

## Interface
- NUM_REQ, 8, number of requesters (one per TQ entry); power of two.
- ID_W, 3, log2(NUM_REQ); width of tq_id.
- ADRS_W, 20, byte-address width.
- CL_W, 128, cache-line data width.
- STARVE_MAX, 4, consecutive FILL_LU grants allowed while a RD/WR request waits (used only with the macro).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-entry request valid.
- req_op  in  NUM_REQ×2  per-entry lookup opcode: NO_LU=0, RD_LU=1, WR_LU=2, FILL_LU=3.
- req_address  in  NUM_REQ×ADRS_W  per-entry address.
- req_cl_data  in  NUM_REQ×CL_W  per-entry line data (write data or fill data).
- req_grant  out  NUM_REQ  one-hot grant pulse, combinational.
- pipe_ready  in  1  lookup pipe accepts lu_req this cycle.
- lu_req_valid  out  1  registered lookup request valid.
- lu_req_op  out  2  granted opcode.
- lu_req_tq_id  out  ID_W  index of the granted entry.
- lu_req_address  out  ADRS_W  granted address.
- lu_req_cl_data  out  CL_W  granted data.

## Operation
- Eligible entry i: req_valid[i]=1 and req_op[i]≠NO_LU. An entry with valid=1 and op=NO_LU is ignored and is never granted.
- Slot free: lu_req_valid=0, or lu_req_valid=1 with pipe_ready=1 in the same cycle (a hand-off and a refill happen in the same cycle).
- Grant happens only when the slot is free and at least one entry is eligible. At most one bit of req_grant is set.
- Round-robin search starts at pointer rr_ptr (ID_W bits) and increases with wrap-around. The first eligible index found wins.
- On a grant:
  - the slot loads {op, i, address, data}.
  - rr_ptr becomes (winner+1) mod NUM_REQ.
- A requester holds its request until it is granted. It must deassert or change the request in the cycle after the grant. A request still held is treated as a new request.
- Slot contents stay stable while lu_req_valid=1 and pipe_ready=0.
- If pipe_ready=1 and there is no grant, lu_req_valid clears next cycle.
- pipe_ready while lu_req_valid=0 has no effect.
- A request that arrives in the same cycle as pipe_ready is eligible in that cycle.
- Reset values: lu_req_valid=0, lu_req_op=0, lu_req_tq_id=0, lu_req_address=0, lu_req_cl_data=0, rr_ptr=0, starve_cnt=0. req_grant=0 whenever rst=1.
- rst in the middle of operation discards any slot contents; the request is not delivered.

## Timing
- Request at cycle N with the slot free → req_grant at N, lu_req_valid=1 at N+1.
- Throughput: one grant per cycle when pipe_ready is held at 1.
- Each blocked cycle (pipe_ready=0) delays all grants by one cycle.
- Zero-cycle bubble across back-to-back grants.
- Worst-case wait with round-robin only: NUM_REQ−1 other grants.

## Configuration
- Macro: CACHE_LU_ARB_FILL_PRIO_EN.
- Defined:
  - Eligible FILL_LU entries win over RD/WR entries. Round-robin applies within each class, using the shared rr_ptr.
  - Saturating counter starve_cnt counts consecutive FILL grants made while some RD/WR entry was eligible.
  - When starve_cnt=STARVE_MAX, the next grant is forced to the RD/WR class; starve_cnt then resets to 0.
  - starve_cnt also resets on any RD/WR grant, and on any cycle where no RD/WR entry is eligible.
- Undefined: plain round-robin across all opcodes. starve_cnt is absent.

## Test plan
- Reset, then req_valid=0x04 with op RD_LU and pipe_ready=1 → grant=0x04 at cycle N; at N+1 lu_req_valid=1, tq_id=2, op=1; rr_ptr=3.
- All 8 entries request RD_LU continuously with pipe_ready=1 → tq_id sequence 0,1,…,7,0 with no bubbles.
- Entry 5 requests WR_LU with pipe_ready=0 for 3 cycles → slot holds tq_id=5 unchanged; entry 6's request gets no grant until the cycle pipe_ready=1, then is granted in that same cycle.
- Entry 3 holds valid=1 with op=NO_LU while entry 1 requests RD_LU → only entry 1 is ever granted.
- With the macro defined: entries 0–3 request FILL_LU and entry 7 requests RD_LU, all held → four FILL grants, then tq_id=7, then FILLs again. Without the macro: round-robin order 0,1,2,3,7.
- rst asserted while lu_req_valid=1 and pipe_ready=0 → next cycle all outputs are 0 and the next grant starts the search at index 0.
